seq_chunk_comparator: RTL and testbench



---
 rtl/seq_chunk_comparator.sv | 97 +++++++++
 tb/tb_seq_chunk_comparator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_comparator.sv
// Serial magnitude comparator for wide operands: examines one CHUNK-bit slice per
// clock, MSB slice first, stopping at the first differing slice.
module seq_chunk_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             smode;
    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic             last;

    // Operand capture; no reset needed since nothing reads these while idle.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opa   <= in1;
            opb   <= in2;
            smode <= signed_mode;
        end
    end

    // Slice select; flipping the top bit of the MSB slice turns a
    // two's-complement compare into an offset-binary (unsigned) compare.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                sa = opa[i*CHUNK +: CHUNK];
                sb = opb[i*CHUNK +: CHUNK];
            end
        end
        if (smode && idx == IW'(N - 1)) begin
            sa[CHUNK-1] = ~sa[CHUNK-1];
            sb[CHUNK-1] = ~sb[CHUNK-1];
        end
        last = (sa != sb) || (idx == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            EQ    <= 1'b0;
            GT    <= 1'b0;
            LT    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= IW'(N - 1);
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (last) begin
                        EQ    <= (sa == sb);
                        GT    <= (sa > sb);
                        LT    <= (sa < sb);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Directed bench for seq_chunk_comparator: a vector table for latency and result,
// plus hand sequences for reset, handshake and back-to-back starts.
module tb_seq_chunk_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic        signed_mode;
    logic [31:0] in1, in2;
    logic        busy1, done1, eq1, gt1, lt1;
    logic        busy2, done2, eq2, gt2, lt2;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          m;
        logic [2:0]  res;
    } vec_t;

    vec_t vecs[9];

    seq_chunk_comparator #(.WIDTH(32), .CHUNK(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode),
        .in1(in1), .in2(in2), .busy(busy1), .done(done1),
        .EQ(eq1), .GT(gt1), .LT(lt1)
    );

    seq_chunk_comparator #(.WIDTH(32), .CHUNK(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(signed_mode),
        .in1(in1), .in2(in2), .busy(busy2), .done(done2),
        .EQ(eq2), .GT(gt2), .LT(lt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmp(input bit wide, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int exp_m, input logic [2:0] exp_res,
                           input string tag);
        int   lat;
        logic busy_ok;
        logic d, bz;
        @(negedge clk);
        in1 = a; in2 = b; signed_mode = sgn;
        if (wide) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        check({tag, " busy_after_start"}, wide ? busy2 : busy1, 1);
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            d  = wide ? done2 : done1;
            bz = wide ? busy2 : busy1;
            if (d) begin
                lat = c;
                break;
            end
            if (!bz) busy_ok = 1'b0;
        end
        check({tag, " latency"}, lat, exp_m);
        check({tag, " result"}, wide ? {eq2, gt2, lt2} : {eq1, gt1, lt1}, exp_res);
        check({tag, " busy_held"}, busy_ok, 1);
        check({tag, " busy_at_done"}, wide ? busy2 : busy1, 0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, wide ? done2 : done1, 0);
        check({tag, " result_held"}, wide ? {eq2, gt2, lt2} : {eq1, gt1, lt1}, exp_res);
    endtask

    initial begin
        int ndone, lat;
        logic nodone;

        vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 16, R_EQ};
        vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1,  R_GT};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1,  R_LT};
        vecs[3] = '{32'h00000001, 32'h00000000, 1'b0, 16, R_GT};
        vecs[4] = '{32'h00000000, 32'h00000001, 1'b1, 16, R_LT};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1,  R_LT};
        vecs[6] = '{32'h00300000, 32'h00200000, 1'b0, 6,  R_GT};
        vecs[7] = '{32'h12345678, 32'h12345679, 1'b0, 16, R_LT};
        vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1,  R_GT};

        rst = 1'b1; start1 = 1'b1; start2 = 1'b1;
        signed_mode = 1'b0; in1 = '0; in2 = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("reset dut1 outputs", {busy1, done1, eq1, gt1, lt1}, 0);
            check("reset dut2 outputs", {busy2, done2, eq2, gt2, lt2}, 0);
        end
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
        @(posedge clk); #1;
        check("idle after reset", {busy1, done1, eq1, gt1, lt1}, 0);

        for (int i = 0; i < 9; i++)
            run_cmp(1'b0, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].m, vecs[i].res,
                    $sformatf("vec%0d", i));

        run_cmp(1'b1, 32'h00000001, 32'h00000000, 1'b0, 1, R_GT, "wide lsb");
        run_cmp(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1, R_EQ, "wide eq");
        run_cmp(1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1, R_LT, "wide signed");

        // Operand changes and a second start during busy must be ignored.
        @(negedge clk);
        in1 = 32'h00000010; in2 = 32'h00000000; signed_mode = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        ndone = 0; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin in1 = 32'h0; in2 = 32'hFFFFFFFF; signed_mode = 1'b1; start1 = 1'b1; end
            if (c == 4) start1 = 1'b0;
            if (done1) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    check("ignore_start result", {eq1, gt1, lt1}, R_GT);
                end
            end
        end
        check("ignore_start done count", ndone, 1);
        check("ignore_start latency", lat, 14);

        // Start presented in the done cycle is accepted at the next edge.
        @(negedge clk);
        in1 = 32'h80000000; in2 = 32'h0; signed_mode = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        check("b2b first done", done1, 1);
        check("b2b first result", {eq1, gt1, lt1}, R_GT);
        in1 = 32'h00000000; in2 = 32'h10000000; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b second busy", busy1, 1);
        check("b2b result held", {eq1, gt1, lt1}, R_GT);
        @(posedge clk); #1;
        check("b2b not done early", done1, 0);
        @(posedge clk); #1;
        check("b2b second done", done1, 1);
        check("b2b second result", {eq1, gt1, lt1}, R_LT);

        // Reset mid-compare aborts and clears the held result.
        @(negedge clk);
        in1 = 32'h12345678; in2 = 32'h12345678; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        nodone = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (done1) nodone = 1'b0;
        end
        check("abort no early done", nodone, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort outputs cleared", {busy1, done1, eq1, gt1, lt1}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmp(1'b0, 32'h12345678, 32'h12345678, 1'b0, 16, R_EQ, "after abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
